enc_width_converter_32to16: RTL and testbench
=============================================

ENC_WIDTH_CONVERTER_32TO16 -- requirements
Module: enc_width_converter_32to16

Interface
REQ-001 SHALL have parameter InputDataWidth, default 32, source word width.
REQ-002 SHALL have parameter OutputDataWidth, default 16, converted word width; InputDataWidth SHALL equal 2*OutputDataWidth.
REQ-003 SHALL have port iClock  input  1  clock; all state updates on its rising edge.
REQ-004 SHALL have port iReset  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port iSrcDataValid  input  1  source word valid.
REQ-006 SHALL have port iSrcDataLast  input  1  source word is last of the frame.
REQ-007 SHALL have port iSrcHalfOnly  input  1  source word carries only its upper half; meaningful only with iSrcDataLast.
REQ-008 SHALL have port iSrcData  input  InputDataWidth  source word.
REQ-009 SHALL have port oConverterReady  output  1  block accepts a source word this cycle.
REQ-010 SHALL have port oConvertedDataValid  output  1  converted half valid.
REQ-011 SHALL have port oConvertedDataLast  output  1  converted half is last of the frame.
REQ-012 SHALL have port oConvertedData  output  OutputDataWidth  converted half.
REQ-013 SHALL have port iDstReady  input  1  encoder accepts converted half.

Function
REQ-014 SHALL accept a source word when iSrcDataValid & oConverterReady (source fire), and emit a half when oConvertedDataValid & iDstReady (output fire).
REQ-015 SHALL hold an output stage (word, last, half-only, valid) and one skid buffer (word, last, half-only, valid).
REQ-016 SHALL drive oConverterReady = NOT buffer-valid, from registered state only, no combinational path from iDstReady.
REQ-017 SHALL use state machine EMPTY, UPPER, LOWER for the output stage; oConvertedDataValid high in UPPER and LOWER only.
REQ-018 SHALL present bits [31:16] in UPPER and bits [15:0] in LOWER (upper half first).
REQ-019 EMPTY: source fire loads output stage directly -> UPPER next cycle (one-cycle latency input to first half).
REQ-020 UPPER, output fire: -> LOWER unless half-only set; if half-only, treat as word completion (REQ-021).
REQ-021 Word completion (output fire in LOWER, or in UPPER with half-only): load from buffer if buffer-valid (buffer cleared) -> UPPER; else load from a simultaneous source fire -> UPPER; else -> EMPTY.
REQ-022 Source fire while output stage occupied and not completing this cycle SHALL write the skid buffer.
REQ-023 Source fire in the completion cycle with buffer empty SHALL bypass to output stage, not buffer.
REQ-024 No output fire SHALL hold state, oConvertedData and oConvertedDataLast stable.
REQ-025 oConvertedDataLast SHALL assert only on the final half of a last word: LOWER of a last word, or UPPER of a last half-only word.
REQ-026 iSrcHalfOnly without iSrcDataLast SHALL be ignored (word emitted as two halves).
REQ-027 Sustained throughput SHALL be one half per cycle with iSrcDataValid and iDstReady held high; no bubbles between words.
REQ-028 Data SHALL never be dropped or duplicated; order preserved.

Reset
REQ-029 On iReset: state EMPTY, both valid flags 0, oConvertedDataValid 0, oConvertedDataLast 0, oConvertedData 0, oConverterReady 1.
REQ-030 Reset mid-frame SHALL discard output stage and buffer contents; first cycle after reset behaves as EMPTY.

Structure
REQ-031 State encodings (EMPTY/UPPER/LOWER, one-hot) and width constants SHALL live in the shared encoder package.
REQ-032 The skid buffer SHALL be a sub-module enc_skid_reg (word, last, half-only, valid); remainder flat.

Verification
REQ-033 Single word 0xAAAA5555, last=1, iDstReady=1 -> halves 0xAAAA then 0x5555 on consecutive cycles, last only on 0x5555, valid low after.
REQ-034 Four back-to-back words 0x00010002..0x00070008, both sides always ready -> 0x0001..0x0008 on eight consecutive cycles, no gaps, oConverterReady toggles as buffer fills/drains.
REQ-035 iDstReady low 5 cycles during LOWER of 0x12345678 with next word pending -> 0x5678 held stable, oConverterReady 0 once buffer full, no loss.
REQ-036 Last word 0xBEEF0000 with iSrcHalfOnly=1 -> single half 0xBEEF with last=1; LOWER never entered.
REQ-037 iSrcHalfOnly=1, iSrcDataLast=0 on 0xCAFEF00D -> 0xCAFE, 0xF00D, last=0 both.
REQ-038 iReset asserted with both stages full -> next cycle valid 0, ready 1; new word after reset emitted correctly.

Source files
------------

// File: rtl/enc_width_converter_32to16_pkg.sv
// Shared encoder definitions: datapath widths and the one-hot output stage
// states used by the 32-to-16 width converter.
package enc_width_converter_32to16_pkg;

   localparam int ENC_IN_WIDTH  = 32;
   localparam int ENC_OUT_WIDTH = 16;

   typedef enum logic [2:0] {
      ST_EMPTY = 3'b001,
      ST_UPPER = 3'b010,
      ST_LOWER = 3'b100
   } conv_state_e;

   // True when the half currently presented is the last half of its word,
   // so an output fire in this state retires the whole word.
   function automatic logic is_final_half(input conv_state_e st, input logic half_only);
      return (st == ST_LOWER) || ((st == ST_UPPER) && half_only);
   endfunction

endpackage

// File: rtl/enc_width_converter_32to16_skid_reg.sv
// Single-entry skid register holding one source word with its frame flags.
// The owner guarantees write and clear are never requested together.
module enc_skid_reg #(
   parameter int Width = 32
) (
   input  logic             iClock,
   input  logic             iReset,
   input  logic             iWrite,
   input  logic             iClear,
   input  logic [Width-1:0] iWord,
   input  logic             iLast,
   input  logic             iHalfOnly,
   output logic [Width-1:0] oWord,
   output logic             oLast,
   output logic             oHalfOnly,
   output logic             oValid
);

   logic [Width-1:0] word_q, word_d;
   logic             last_q, last_d;
   logic             half_q, half_d;
   logic             valid_q, valid_d;

   // Capture a word on write, drop the valid flag when the word is taken.
   always_comb begin
      word_d  = word_q;
      last_d  = last_q;
      half_d  = half_q;
      valid_d = valid_q;
      if (iClear) begin
         valid_d = 1'b0;
      end
      if (iWrite) begin
         word_d  = iWord;
         last_d  = iLast;
         half_d  = iHalfOnly;
         valid_d = 1'b1;
      end
   end

   // Register the entry; reset empties it and clears the stored contents.
   always_ff @(posedge iClock) begin
      if (iReset) begin
         word_q  <= '0;
         last_q  <= 1'b0;
         half_q  <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         word_q  <= word_d;
         last_q  <= last_d;
         half_q  <= half_d;
         valid_q <= valid_d;
      end
   end

   assign oWord     = word_q;
   assign oLast     = last_q;
   assign oHalfOnly = half_q;
   assign oValid    = valid_q;

endmodule

// File: rtl/enc_width_converter_32to16.sv
// Splits each source word into two halves, upper half first, toward the
// encoder. A one-word skid register decouples the source ready from the
// encoder ready so that ready stays purely registered, yet a half can still
// be emitted every cycle. Last words flagged half-only emit the upper half alone.
// InputDataWidth must be exactly twice OutputDataWidth.
module enc_width_converter_32to16
   import enc_width_converter_32to16_pkg::*;
#(
   parameter int InputDataWidth  = ENC_IN_WIDTH,
   parameter int OutputDataWidth = ENC_OUT_WIDTH
) (
   input  logic                       iClock,
   input  logic                       iReset,
   input  logic                       iSrcDataValid,
   input  logic                       iSrcDataLast,
   input  logic                       iSrcHalfOnly,
   input  logic [InputDataWidth-1:0]  iSrcData,
   output logic                       oConverterReady,
   output logic                       oConvertedDataValid,
   output logic                       oConvertedDataLast,
   output logic [OutputDataWidth-1:0] oConvertedData,
   input  logic                       iDstReady
);

   conv_state_e               state_q, state_d;
   logic [InputDataWidth-1:0] word_q, word_d;
   logic                      last_q, last_d;
   logic                      half_q, half_d;

   logic                      src_half_only;
   logic                      src_fire;
   logic                      out_fire;
   logic                      stage_busy;
   logic                      completing;
   logic                      buf_write;
   logic                      buf_clear;
   logic [InputDataWidth-1:0] buf_word;
   logic                      buf_last;
   logic                      buf_half;
   logic                      buf_valid;

   // Half-only is only honoured on the last word of a frame.
   assign src_half_only   = iSrcHalfOnly & iSrcDataLast;
   assign oConverterReady = ~buf_valid;
   assign src_fire        = iSrcDataValid & ~buf_valid;
   assign stage_busy      = (state_q != ST_EMPTY);
   assign out_fire        = stage_busy & iDstReady;
   assign completing      = out_fire & is_final_half(state_q, half_q);
   assign buf_write       = src_fire & stage_busy & ~completing;
   assign buf_clear       = completing & buf_valid;

   enc_skid_reg #(
      .Width(InputDataWidth)
   ) u_skid (
      .iClock   (iClock),
      .iReset   (iReset),
      .iWrite   (buf_write),
      .iClear   (buf_clear),
      .iWord    (iSrcData),
      .iLast    (iSrcDataLast),
      .iHalfOnly(src_half_only),
      .oWord    (buf_word),
      .oLast    (buf_last),
      .oHalfOnly(buf_half),
      .oValid   (buf_valid)
   );

   // Output stage sequencing: load when empty, advance on output fire, and on
   // word completion refill from the skid entry first, then from the source.
   always_comb begin
      state_d = state_q;
      word_d  = word_q;
      last_d  = last_q;
      half_d  = half_q;
      case (state_q)
         ST_EMPTY: begin
            if (src_fire) begin
               word_d  = iSrcData;
               last_d  = iSrcDataLast;
               half_d  = src_half_only;
               state_d = ST_UPPER;
            end
         end
         ST_UPPER, ST_LOWER: begin
            if (completing) begin
               if (buf_valid) begin
                  word_d  = buf_word;
                  last_d  = buf_last;
                  half_d  = buf_half;
                  state_d = ST_UPPER;
               end else if (src_fire) begin
                  word_d  = iSrcData;
                  last_d  = iSrcDataLast;
                  half_d  = src_half_only;
                  state_d = ST_UPPER;
               end else begin
                  state_d = ST_EMPTY;
               end
            end else if (out_fire) begin
               state_d = ST_LOWER;
            end
         end
         default: begin
            state_d = ST_EMPTY;
         end
      endcase
   end

   // Output stage register; reset discards any word in flight.
   always_ff @(posedge iClock) begin
      if (iReset) begin
         state_q <= ST_EMPTY;
         word_q  <= '0;
         last_q  <= 1'b0;
         half_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         word_q  <= word_d;
         last_q  <= last_d;
         half_q  <= half_d;
      end
   end

   // Present the half selected by the state; outputs are quiet when empty.
   always_comb begin
      oConvertedDataValid = 1'b0;
      oConvertedDataLast  = 1'b0;
      oConvertedData      = '0;
      case (state_q)
         ST_UPPER: begin
            oConvertedDataValid = 1'b1;
            oConvertedData      = word_q[InputDataWidth-1:OutputDataWidth];
            oConvertedDataLast  = last_q & half_q;
         end
         ST_LOWER: begin
            oConvertedDataValid = 1'b1;
            oConvertedData      = word_q[OutputDataWidth-1:0];
            oConvertedDataLast  = last_q;
         end
         default: begin
         end
      endcase
   end

endmodule

// File: tb/tb_enc_width_converter_32to16.sv
// Testbench for the 32-to-16 width converter: directed scenarios with literal
// expectations, plus a queue model of expected halves checked every cycle.
module tb_enc_width_converter_32to16;

   logic        iClock = 1'b0;
   logic        iReset = 1'b1;
   logic        iSrcDataValid = 1'b0;
   logic        iSrcDataLast = 1'b0;
   logic        iSrcHalfOnly = 1'b0;
   logic [31:0] iSrcData = 32'h0;
   logic        iDstReady = 1'b0;
   logic        oConverterReady;
   logic        oConvertedDataValid;
   logic        oConvertedDataLast;
   logic [15:0] oConvertedData;

   int checks = 0;
   int failures = 0;

   typedef struct packed {
      logic [15:0] data;
      logic        last;
   } half_t;

   half_t exp_q[$];
   logic  prev_stall = 1'b0;
   half_t prev_out;

   logic [31:0] words34 [4] = '{32'h00010002, 32'h00030004, 32'h00050006, 32'h00070008};
   logic [15:0] e34d [10] = '{16'h0, 16'h1, 16'h2, 16'h3, 16'h4, 16'h5, 16'h6, 16'h7, 16'h8, 16'h0};
   logic        e34v [10] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
   logic        e34r [10] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};

   enc_width_converter_32to16 #(
      .InputDataWidth (32),
      .OutputDataWidth(16)
   ) dut (
      .iClock             (iClock),
      .iReset             (iReset),
      .iSrcDataValid      (iSrcDataValid),
      .iSrcDataLast       (iSrcDataLast),
      .iSrcHalfOnly       (iSrcHalfOnly),
      .iSrcData           (iSrcData),
      .oConverterReady    (oConverterReady),
      .oConvertedDataValid(oConvertedDataValid),
      .oConvertedDataLast (oConvertedDataLast),
      .oConvertedData     (oConvertedData),
      .iDstReady          (iDstReady)
   );

   // Free-running clock, 10 time-unit period.
   always #5 iClock = ~iClock;

   // Reference model: every accepted word becomes its halves in a queue; any
   // valid output must match the queue head, and a stalled half must not move.
   always @(negedge iClock) begin
      half_t h;
      if (iReset) begin
         exp_q.delete();
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            checks++;
            if ({oConvertedDataValid, oConvertedData, oConvertedDataLast} !== {1'b1, prev_out}) begin
               failures++;
               $display("[TB] FAIL hold_stable: got v=%0b d=%h l=%0b required v=1 d=%h l=%0b",
                        oConvertedDataValid, oConvertedData, oConvertedDataLast, prev_out.data, prev_out.last);
            end
         end
         if (oConvertedDataValid) begin
            checks++;
            if (exp_q.size() == 0) begin
               failures++;
               $display("[TB] FAIL model_extra: got d=%h l=%0b required no valid half", oConvertedData, oConvertedDataLast);
            end else if ({oConvertedData, oConvertedDataLast} !== exp_q[0]) begin
               failures++;
               $display("[TB] FAIL model_order: got d=%h l=%0b required d=%h l=%0b",
                        oConvertedData, oConvertedDataLast, exp_q[0].data, exp_q[0].last);
            end
            if (iDstReady && exp_q.size() > 0) void'(exp_q.pop_front());
         end
         prev_stall = oConvertedDataValid & ~iDstReady;
         prev_out   = {oConvertedData, oConvertedDataLast};
         if (iSrcDataValid && oConverterReady) begin
            if (iSrcDataLast && iSrcHalfOnly) begin
               h = {iSrcData[31:16], 1'b1};
               exp_q.push_back(h);
            end else begin
               h = {iSrcData[31:16], 1'b0};
               exp_q.push_back(h);
               h = {iSrcData[15:0], iSrcDataLast};
               exp_q.push_back(h);
            end
         end
      end
   end

   task automatic applyStimulus(input logic v, input logic [31:0] d, input logic l,
                                input logic h, input logic dr);
      iSrcDataValid = v;
      iSrcData      = d;
      iSrcDataLast  = l;
      iSrcHalfOnly  = h;
      iDstReady     = dr;
   endtask

   task automatic nextCycle();
      @(posedge iClock);
      #1;
   endtask

   task automatic sample();
      @(negedge iClock);
   endtask

   // With strict set, data and last are compared even when valid is low.
   task automatic checkOutput(input string name, input logic ev, input logic [15:0] ed,
                              input logic el, input bit strict);
      checks++;
      if (oConvertedDataValid !== ev ||
          ((ev || strict) && (oConvertedData !== ed || oConvertedDataLast !== el))) begin
         failures++;
         $display("[TB] FAIL %s: got v=%0b d=%h l=%0b required v=%0b d=%h l=%0b",
                  name, oConvertedDataValid, oConvertedData, oConvertedDataLast, ev, ed, el);
      end
   endtask

   task automatic checkReady(input string name, input logic er);
      checks++;
      if (oConverterReady !== er) begin
         failures++;
         $display("[TB] FAIL %s: got ready=%0b required ready=%0b", name, oConverterReady, er);
      end
   endtask

   // Directed scenarios followed by a short randomised soak and a drain check.
   initial begin
      int idx;

      // Reset with a valid source word present: it must be ignored.
      applyStimulus(1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 1'b1);
      repeat (3) nextCycle();
      sample();
      checkOutput("reset_outputs", 1'b0, 16'h0, 1'b0, 1'b1);
      checkReady("reset_ready", 1'b1);
      nextCycle();
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
      iReset = 1'b0;
      nextCycle();

      // Single last word split into two halves.
      $display("[TB] single word");
      applyStimulus(1'b1, 32'hAAAA5555, 1'b1, 1'b0, 1'b1);
      sample();
      checkOutput("single_idle", 1'b0, 16'h0, 1'b0, 1'b0);
      checkReady("single_ready", 1'b1);
      nextCycle();
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
      sample();
      checkOutput("single_upper", 1'b1, 16'hAAAA, 1'b0, 1'b0);
      nextCycle();
      sample();
      checkOutput("single_lower", 1'b1, 16'h5555, 1'b1, 1'b0);
      nextCycle();
      sample();
      checkOutput("single_after", 1'b0, 16'h0, 1'b0, 1'b0);
      nextCycle();

      // Four back-to-back words at full throughput.
      $display("[TB] back-to-back");
      idx = 0;
      for (int k = 0; k < 10; k++) begin
         if (idx < 4) applyStimulus(1'b1, words34[idx], (idx == 3), 1'b0, 1'b1);
         else         applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
         sample();
         checkOutput($sformatf("b2b_out%0d", k), e34v[k], e34d[k], (k == 8), 1'b0);
         checkReady($sformatf("b2b_ready%0d", k), e34r[k]);
         if (iSrcDataValid && oConverterReady) idx++;
         nextCycle();
      end

      // Encoder stall during the lower half with a second word pending.
      $display("[TB] stall");
      applyStimulus(1'b1, 32'h12345678, 1'b0, 1'b0, 1'b1);
      sample();
      checkReady("stall_ready0", 1'b1);
      nextCycle();
      applyStimulus(1'b1, 32'h9ABCDEF0, 1'b1, 1'b0, 1'b1);
      sample();
      checkOutput("stall_upper", 1'b1, 16'h1234, 1'b0, 1'b0);
      checkReady("stall_ready1", 1'b1);
      nextCycle();
      for (int k = 0; k < 5; k++) begin
         applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
         sample();
         checkOutput($sformatf("stall_hold%0d", k), 1'b1, 16'h5678, 1'b0, 1'b0);
         checkReady($sformatf("stall_full%0d", k), 1'b0);
         nextCycle();
      end
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
      sample();
      checkOutput("stall_release", 1'b1, 16'h5678, 1'b0, 1'b0);
      nextCycle();
      sample();
      checkOutput("stall_next_upper", 1'b1, 16'h9ABC, 1'b0, 1'b0);
      checkReady("stall_drained", 1'b1);
      nextCycle();
      sample();
      checkOutput("stall_next_lower", 1'b1, 16'hDEF0, 1'b1, 1'b0);
      nextCycle();
      sample();
      checkOutput("stall_after", 1'b0, 16'h0, 1'b0, 1'b0);
      nextCycle();

      // Last word carrying only its upper half.
      $display("[TB] half-only last");
      applyStimulus(1'b1, 32'hBEEF0000, 1'b1, 1'b1, 1'b1);
      sample();
      nextCycle();
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
      sample();
      checkOutput("halfonly_upper", 1'b1, 16'hBEEF, 1'b1, 1'b0);
      nextCycle();
      sample();
      checkOutput("halfonly_after", 1'b0, 16'h0, 1'b0, 1'b0);
      nextCycle();

      // Half-only without last must still produce both halves.
      $display("[TB] half-only ignored");
      applyStimulus(1'b1, 32'hCAFEF00D, 1'b0, 1'b1, 1'b1);
      sample();
      nextCycle();
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
      sample();
      checkOutput("ignored_upper", 1'b1, 16'hCAFE, 1'b0, 1'b0);
      nextCycle();
      sample();
      checkOutput("ignored_lower", 1'b1, 16'hF00D, 1'b0, 1'b0);
      nextCycle();
      sample();
      checkOutput("ignored_after", 1'b0, 16'h0, 1'b0, 1'b0);
      nextCycle();

      // Reset with output stage and skid entry both occupied.
      $display("[TB] reset while full");
      applyStimulus(1'b1, 32'h0BAD0001, 1'b0, 1'b0, 1'b0);
      sample();
      nextCycle();
      applyStimulus(1'b1, 32'h0BAD0002, 1'b1, 1'b0, 1'b0);
      sample();
      checkOutput("full_upper", 1'b1, 16'h0BAD, 1'b0, 1'b0);
      nextCycle();
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
      sample();
      checkReady("full_ready", 1'b0);
      nextCycle();
      iReset = 1'b1;
      sample();
      nextCycle();
      iReset = 1'b0;
      sample();
      checkOutput("postreset_outputs", 1'b0, 16'h0, 1'b0, 1'b1);
      checkReady("postreset_ready", 1'b1);
      nextCycle();
      applyStimulus(1'b1, 32'h11223344, 1'b1, 1'b0, 1'b1);
      sample();
      nextCycle();
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
      sample();
      checkOutput("postreset_upper", 1'b1, 16'h1122, 1'b0, 1'b0);
      nextCycle();
      sample();
      checkOutput("postreset_lower", 1'b1, 16'h3344, 1'b1, 1'b0);
      nextCycle();
      sample();
      checkOutput("postreset_after", 1'b0, 16'h0, 1'b0, 1'b0);
      nextCycle();

      // Randomised traffic and back-pressure, checked by the queue model only.
      $display("[TB] random soak");
      for (int k = 0; k < 80; k++) begin
         applyStimulus($urandom_range(0, 1) == 1, $urandom(), $urandom_range(0, 3) == 0,
                       $urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0);
         nextCycle();
      end
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
      repeat (6) nextCycle();
      sample();
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("[TB] FAIL drain_empty: got %0d halves still expected, required 0", exp_q.size());
      end
      checkOutput("drain_idle", 1'b0, 16'h0, 1'b0, 1'b0);
      checkReady("drain_ready", 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
